// File: rtl/bcast_seq_ctrl.sv
// Broadcast-unit sequencer: loads a vector cache from SRAM, then issues broadcast beats.
// Optional stall counter output enabled by defining BCAST_SEQ_CTRL_PERF_EN.
module bcast_seq_ctrl #(
  parameter int MAX_VECTOR_SIZE = 8,
  parameter int CACHE_DEPTH     = 512,
  parameter int RD_LAT          = 1,
  parameter int MAX_ADDR_WIDTH  = 32,
  parameter int INT32_SIZE      = 32,
  parameter int INT8_SIZE       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [MAX_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [INT32_SIZE-1:0]     num_elem_i,
  input  logic [INT32_SIZE-1:0]     num_beats_i,
  input  logic                      stall_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      sram_rd_en_o,
  output logic [MAX_ADDR_WIDTH-1:0] sram_addr_o,
  input  logic [8*INT8_SIZE-1:0]    sram_rdata_i,
  output logic                      bu_init_o,
  output logic                      bu_valid_o,
  output logic                      bu_en_o,
  output logic [MAX_ADDR_WIDTH-1:0] bu_addr_o,
  output logic [8*INT8_SIZE-1:0]    bu_data_o,
`ifdef BCAST_SEQ_CTRL_PERF_EN
  output logic [31:0]               stall_cnt_o,
`endif
  output logic [INT32_SIZE-1:0]     bu_num_elem_o
);

  localparam int RCW = $clog2(CACHE_DEPTH / MAX_VECTOR_SIZE) + 1;
  localparam logic [MAX_ADDR_WIDTH-1:0] VEC_STEP = MAX_ADDR_WIDTH'(MAX_VECTOR_SIZE);

  typedef enum logic [2:0] {IDLE, INIT, LOAD, STREAM, DONE} state_t;

  state_t                    state_q;
  logic [MAX_ADDR_WIDTH-1:0] base_q;
  logic [INT32_SIZE-1:0]     num_elem_q;
  logic [INT32_SIZE-1:0]     num_beats_q;
  logic [RCW-1:0]            k_total_q;
  logic [RCW-1:0]            rd_issued_q;
  logic [RCW-1:0]            rd_idx_q;
  logic [RCW-1:0]            rsp_cnt_q;
  logic [31:0]               beat_cnt_q;
  logic                      rd_en_q;
  logic [MAX_ADDR_WIDTH-1:0] rd_addr_q;
  logic                      err_q;
  logic [RD_LAT-1:0]         pv_q;
  logic [RCW-1:0]            pidx_q [RD_LAT];
`ifdef BCAST_SEQ_CTRL_PERF_EN
  logic [31:0]               stall_cnt_q;
`endif

  logic                  start_ok;
  logic [INT32_SIZE-1:0] k_full;
  logic                  rsp_fire;
  logic                  beat_fire;

  assign start_ok  = (num_elem_i != '0) && (num_elem_i <= INT32_SIZE'(CACHE_DEPTH));
  assign k_full    = (num_elem_i + INT32_SIZE'(MAX_VECTOR_SIZE - 1)) / INT32_SIZE'(MAX_VECTOR_SIZE);
  assign rsp_fire  = pv_q[RD_LAT-1];
  assign beat_fire = (state_q == STREAM) && !stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_elem_q  <= '0;
      num_beats_q <= '0;
      k_total_q   <= '0;
      rd_issued_q <= '0;
      rd_idx_q    <= '0;
      rsp_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      err_q       <= 1'b0;
      pv_q        <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx_q[i] <= '0;
`ifdef BCAST_SEQ_CTRL_PERF_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      err_q     <= 1'b0;
      // Tag pipeline: tail entry lines up with the SRAM data of the same read.
      pv_q[0]   <= rd_en_q;
      pidx_q[0] <= rd_idx_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (start_ok) begin
              state_q     <= INIT;
              base_q      <= base_addr_i;
              num_elem_q  <= num_elem_i;
              num_beats_q <= num_beats_i;
              k_total_q   <= RCW'(k_full);
              rsp_cnt_q   <= '0;
              beat_cnt_q  <= '0;
`ifdef BCAST_SEQ_CTRL_PERF_EN
              stall_cnt_q <= '0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        INIT: begin
          state_q     <= LOAD;
          rd_en_q     <= 1'b1;
          rd_addr_q   <= base_q;
          rd_idx_q    <= '0;
          rd_issued_q <= RCW'(1);
        end
        LOAD: begin
          if (rd_issued_q < k_total_q) begin
            rd_en_q     <= 1'b1;
            rd_addr_q   <= rd_addr_q + VEC_STEP;
            rd_idx_q    <= rd_issued_q;
            rd_issued_q <= rd_issued_q + RCW'(1);
          end else begin
            rd_en_q <= 1'b0;
          end
          if (rsp_fire) begin
            rsp_cnt_q <= rsp_cnt_q + RCW'(1);
            if (rsp_cnt_q == k_total_q - RCW'(1))
              state_q <= (num_beats_q == '0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            if (beat_cnt_q == 32'(num_beats_q) - 32'd1) state_q <= DONE;
          end
`ifdef BCAST_SEQ_CTRL_PERF_EN
          if (stall_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced low combinationally so the reset cycle itself is quiet.
  assign busy_o        = !rst && (state_q != IDLE);
  assign done_o        = !rst && (state_q == DONE);
  assign err_o         = !rst && err_q;
  assign bu_init_o     = !rst && (state_q == INIT);
  assign sram_rd_en_o  = !rst && rd_en_q;
  assign sram_addr_o   = sram_rd_en_o ? rd_addr_q : '0;
  assign bu_valid_o    = !rst && rsp_fire;
  assign bu_data_o     = bu_valid_o ? sram_rdata_i : '0;
  assign bu_addr_o     = bu_valid_o ? MAX_ADDR_WIDTH'(pidx_q[RD_LAT-1]) * VEC_STEP : '0;
  assign bu_en_o       = !rst && beat_fire;
  assign bu_num_elem_o = rst ? '0 : num_elem_q;
`ifdef BCAST_SEQ_CTRL_PERF_EN
  assign stall_cnt_o   = rst ? '0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_bcast_seq_ctrl.sv
// Directed bench for bcast_seq_ctrl: SRAM model with RD_LAT=2 and per-job event logging.
module tb_bcast_seq_ctrl;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] num_elem_i;
  logic [31:0] num_beats_i;
  logic        stall_i;
  logic        busy_o, done_o, err_o, sram_rd_en_o;
  logic [31:0] sram_addr_o;
  logic [63:0] sram_rdata_i;
  logic        bu_init_o, bu_valid_o, bu_en_o;
  logic [31:0] bu_addr_o;
  logic [63:0] bu_data_o;
  logic [31:0] bu_num_elem_o;
`ifdef BCAST_SEQ_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  bcast_seq_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_elem_i(num_elem_i), .num_beats_i(num_beats_i), .stall_i(stall_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .sram_rd_en_o(sram_rd_en_o), .sram_addr_o(sram_addr_o), .sram_rdata_i(sram_rdata_i),
    .bu_init_o(bu_init_o), .bu_valid_o(bu_valid_o), .bu_en_o(bu_en_o),
    .bu_addr_o(bu_addr_o), .bu_data_o(bu_data_o),
`ifdef BCAST_SEQ_CTRL_PERF_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .bu_num_elem_o(bu_num_elem_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a, ~a};
  endfunction

  // SRAM model: data for a read appears RD_LAT cycles after the request.
  logic [63:0] mem_pipe [RD_LAT];
  always @(posedge clk) begin
    mem_pipe[0] <= sram_rd_en_o ? mem_word(sram_addr_o) : 64'h0;
    for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign sram_rdata_i = mem_pipe[RD_LAT-1];

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] va_q[$];
  logic [63:0] vd_q[$];
  int en_cnt, first_en, last_en, done_cnt, done_cyc, err_cnt, busy_cnt, last_valid, overlap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return busy_o | done_o | err_o | sram_rd_en_o | (|sram_addr_o) | bu_init_o |
           bu_valid_o | bu_en_o | (|bu_addr_o) | (|bu_data_o) | (|bu_num_elem_o)
`ifdef BCAST_SEQ_CTRL_PERF_EN
           | (|stall_cnt_o)
`endif
           ;
  endfunction

  // Driver: start at cycle 0, optional stall window, restart and reset cycles.
  task automatic run_job(input logic [31:0] base, input logic [31:0] ne, input logic [31:0] nb,
                         input int stall_at, input int stall_len, input int restart_at,
                         input int rst_at, input int ncyc);
    rd_q.delete(); va_q.delete(); vd_q.delete();
    en_cnt = 0; first_en = -1; last_en = -1; done_cnt = 0; done_cyc = -1;
    err_cnt = 0; busy_cnt = 0; last_valid = -1; overlap = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(posedge clk); #1;
      start_i     = (cyc == 0) || (cyc == restart_at);
      base_addr_i = base;
      num_elem_i  = ne;
      num_beats_i = nb;
      stall_i     = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      rst         = (cyc == rst_at);
      @(negedge clk);
      if (rst) check("rst_outputs_zero", {63'b0, any_out()}, 64'h0);
      if (sram_rd_en_o) rd_q.push_back(sram_addr_o);
      if (bu_valid_o) begin
        va_q.push_back(bu_addr_o);
        vd_q.push_back(bu_data_o);
        last_valid = cyc;
      end
      if (bu_en_o) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (bu_valid_o && bu_en_o) overlap++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (err_o) err_cnt++;
      if (busy_o) busy_cnt++;
    end
    @(posedge clk); #1;
    start_i = 1'b0; stall_i = 1'b0; rst = 1'b0;
  endtask

  task automatic check_loads(input string tag, input logic [31:0] base, input int k);
    check({tag, "_rd_cnt"}, 64'(rd_q.size()), 64'(k));
    check({tag, "_valid_cnt"}, 64'(va_q.size()), 64'(k));
    for (int i = 0; i < k; i++) exp_q.push_back(64'(base + 32'(i * 8)));
    while (exp_q.size() > 0 && rd_q.size() > 0)
      check({tag, "_rd_addr"}, 64'(rd_q.pop_front()), exp_q.pop_front());
    exp_q.delete();
    for (int i = 0; i < k && va_q.size() > 0; i++) begin
      check({tag, "_bu_addr"}, 64'(va_q.pop_front()), 64'(i * 8));
      check({tag, "_bu_data"}, vd_q.pop_front(), mem_word(base + 32'(i * 8)));
    end
    check({tag, "_overlap"}, 64'(overlap), 64'h0);
  endtask

  task automatic job_basic(input string tag);
    run_job(32'h40, 32'd20, 32'd3, -1, 0, -1, -1, 14);
    check_loads(tag, 32'h40, 3);
    check({tag, "_en_cnt"}, 64'(en_cnt), 64'd3);
    check({tag, "_first_en"}, 64'(first_en), 64'd7);
    check({tag, "_last_en"}, 64'(last_en), 64'd9);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'd10);
    check({tag, "_busy_cyc"}, 64'(busy_cnt), 64'd10);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_num_elem"}, 64'(bu_num_elem_o), 64'd20);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; stall_i = 1'b0;
    base_addr_i = '0; num_elem_i = '0; num_beats_i = '0;
    for (int i = 0; i < RD_LAT; i++) mem_pipe[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_zero", {63'b0, any_out()}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", {63'b0, busy_o}, 64'h0);
    check("post_reset_num_elem", 64'(bu_num_elem_o), 64'h0);

    job_basic("job1");

    // num_elem=8, num_beats=4, stall in cycles 6..7 of the job
    run_job(32'h100, 32'd8, 32'd4, 6, 2, -1, -1, 14);
    check_loads("stall", 32'h100, 1);
    check("stall_en_cnt", 64'(en_cnt), 64'd4);
    check("stall_stream_cyc", 64'(done_cyc - last_valid - 1), 64'd6);
    check("stall_done_cyc", 64'(done_cyc), 64'd11);
    check("stall_done_cnt", 64'(done_cnt), 64'd1);
`ifdef BCAST_SEQ_CTRL_PERF_EN
    check("stall_cnt", 64'(stall_cnt_o), 64'd2);
`endif

    run_job(32'h200, 32'd0, 32'd2, -1, 0, -1, -1, 6);
    check("err0_err_cnt", 64'(err_cnt), 64'd1);
    check("err0_busy", 64'(busy_cnt), 64'd0);
    check("err0_reads", 64'(rd_q.size()), 64'd0);
    check("err0_done", 64'(done_cnt), 64'd0);

    run_job(32'h200, 32'd513, 32'd2, -1, 0, -1, -1, 6);
    check("err513_err_cnt", 64'(err_cnt), 64'd1);
    check("err513_busy", 64'(busy_cnt), 64'd0);
    check("err513_reads", 64'(rd_q.size()), 64'd0);
    check("err513_done", 64'(done_cnt), 64'd0);
    check("err_keeps_num_elem", 64'(bu_num_elem_o), 64'd8);

    // num_beats=0, plus a second start during LOAD that must be ignored
    run_job(32'h300, 32'd1, 32'd0, -1, 0, 3, -1, 12);
    check_loads("nb0", 32'h300, 1);
    check("nb0_en_cnt", 64'(en_cnt), 64'd0);
    check("nb0_done_cnt", 64'(done_cnt), 64'd1);
    check("nb0_done_cyc", 64'(done_cyc), 64'd5);
    check("nb0_err_cnt", 64'(err_cnt), 64'd0);

    // Reset pulse in cycle 3 (LOAD, one read already in flight)
    run_job(32'h40, 32'd20, 32'd3, -1, 0, -1, 3, 14);
    check("rstjob_reads", 64'(rd_q.size()), 64'd1);
    check("rstjob_valids", 64'(va_q.size()), 64'd0);
    check("rstjob_done", 64'(done_cnt), 64'd0);
    check("rstjob_busy_cyc", 64'(busy_cnt), 64'd2);
    check("rstjob_num_elem", 64'(bu_num_elem_o), 64'd0);

    job_basic("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
